// File: rtl/sme_feeder.sv
// Upstream feeder for the string-match engine: buffers one string line and one pattern line,
// replays them as contiguous bursts and forwards the matcher result. Option: SME_FEEDER_TIMEOUT_EN.
module sme_feeder #(
  parameter int unsigned STR_MAX = 32,
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_kind,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic [1:0] res_err,
  output logic       busy
);

  localparam int unsigned SLW = $clog2(STR_MAX + 1);
  localparam int unsigned PLW = $clog2(PAT_MAX + 1);
  localparam int unsigned IW  = (SLW > PLW) ? SLW : PLW;
  localparam int unsigned SAW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
  localparam int unsigned PAW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSendS,
    StSendP,
    StWait,
    StResp
  } state_e;

  state_e        state_q, state_d;
  logic          kind_q, kind_d;
  logic [IW-1:0] str_len_q, str_len_d;
  logic [IW-1:0] pat_len_q, pat_len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          str_pending_q, str_pending_d;
  logic          str_seen_q, str_seen_d;
  logic          trunc_q, trunc_d;

  logic          in_ready_d, busy_d;
  logic [7:0]    chardata_d;
  logic          isstring_d, ispattern_d;
  logic          res_valid_d, res_match_d;
  logic [4:0]    res_index_d;
  logic [1:0]    res_err_d;

  logic [7:0]    str_buf [STR_MAX];
  logic [7:0]    pat_buf [PAT_MAX];

  logic          beat, first, cur_kind, str_wr, pat_wr, overflow;
  logic [IW-1:0] wr_pos;

`ifdef SME_FEEDER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // Write side: the first beat of a line (seen in IDLE) restarts that kind's counter.
  always_comb begin
    beat     = in_valid & in_ready;
    first    = (state_q == StIdle);
    cur_kind = first ? in_kind : kind_q;
    wr_pos   = first ? '0 : (cur_kind ? pat_len_q : str_len_q);
    str_wr   = beat & ~cur_kind & (wr_pos < IW'(STR_MAX));
    pat_wr   = beat & cur_kind & (wr_pos < IW'(PAT_MAX));
    overflow = beat & ~str_wr & ~pat_wr;
  end

  always_ff @(posedge clk) begin
    if (str_wr) str_buf[wr_pos[SAW-1:0]] <= in_data;
    if (pat_wr) pat_buf[wr_pos[PAW-1:0]] <= in_data;
  end

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    str_len_d     = str_len_q;
    pat_len_d     = pat_len_q;
    idx_d         = idx_q;
    str_pending_d = str_pending_q;
    str_seen_d    = str_seen_q;
    trunc_d       = trunc_q | overflow;
    chardata_d    = 8'd0;
    isstring_d    = 1'b0;
    ispattern_d   = 1'b0;
    res_valid_d   = 1'b0;
    res_match_d   = 1'b0;
    res_index_d   = 5'd0;
    res_err_d     = 2'b00;
`ifdef SME_FEEDER_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif

    unique case (state_q)
      StIdle, StLoad: begin
        if (beat) begin
          kind_d  = cur_kind;
          state_d = StLoad;
          if (!cur_kind) str_len_d = str_wr ? wr_pos + IW'(1) : wr_pos;
          else           pat_len_d = pat_wr ? wr_pos + IW'(1) : wr_pos;
          if (in_last) begin
            if (!cur_kind) begin
              str_pending_d = 1'b1;
              str_seen_d    = 1'b1;
              state_d       = StIdle;
            end else if (str_pending_q) begin
              state_d       = StSendS;
              str_pending_d = 1'b0;
              chardata_d    = str_buf[0];
              isstring_d    = 1'b1;
              idx_d         = IW'(1);
            end else if (str_seen_q) begin
              // A one-byte pattern is still in flight to pat_buf, so bypass it.
              state_d     = StSendP;
              chardata_d  = (wr_pos == '0) ? in_data : pat_buf[0];
              ispattern_d = 1'b1;
              idx_d       = IW'(1);
            end else begin
              state_d     = StResp;
              res_valid_d = 1'b1;
              res_err_d   = {1'b1, trunc_q | overflow};
            end
          end
        end
      end
      StSendS: begin
        if (idx_q < str_len_q) begin
          chardata_d = str_buf[idx_q[SAW-1:0]];
          isstring_d = 1'b1;
          idx_d      = idx_q + IW'(1);
        end else begin
          state_d     = StSendP;
          chardata_d  = pat_buf[0];
          ispattern_d = 1'b1;
          idx_d       = IW'(1);
        end
      end
      StSendP: begin
        if (idx_q < pat_len_q) begin
          chardata_d  = pat_buf[idx_q[PAW-1:0]];
          ispattern_d = 1'b1;
          idx_d       = idx_q + IW'(1);
        end else begin
          state_d = StWait;
`ifdef SME_FEEDER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StWait: begin
`ifdef SME_FEEDER_TIMEOUT_EN
        cnt_d = cnt_q + CW'(1);
`endif
        if (sme_valid) begin
          state_d     = StResp;
          res_valid_d = 1'b1;
          res_match_d = sme_match;
          res_index_d = sme_index;
          res_err_d   = {1'b0, trunc_q};
        end
`ifdef SME_FEEDER_TIMEOUT_EN
        else if (cnt_d == CW'(TIMEOUT)) begin
          state_d     = StResp;
          res_valid_d = 1'b1;
          res_err_d   = {1'b1, trunc_q};
        end
`endif
      end
      StResp: begin
        state_d = StIdle;
        trunc_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    in_ready_d = (state_d == StIdle) || (state_d == StLoad);
    busy_d     = ~in_ready_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      kind_q        <= 1'b0;
      str_len_q     <= '0;
      pat_len_q     <= '0;
      idx_q         <= '0;
      str_pending_q <= 1'b0;
      str_seen_q    <= 1'b0;
      trunc_q       <= 1'b0;
      in_ready      <= 1'b0;
      chardata      <= 8'd0;
      isstring      <= 1'b0;
      ispattern     <= 1'b0;
      res_valid     <= 1'b0;
      res_match     <= 1'b0;
      res_index     <= 5'd0;
      res_err       <= 2'b00;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      str_len_q     <= str_len_d;
      pat_len_q     <= pat_len_d;
      idx_q         <= idx_d;
      str_pending_q <= str_pending_d;
      str_seen_q    <= str_seen_d;
      trunc_q       <= trunc_d;
      in_ready      <= in_ready_d;
      chardata      <= chardata_d;
      isstring      <= isstring_d;
      ispattern     <= ispattern_d;
      res_valid     <= res_valid_d;
      res_match     <= res_match_d;
      res_index     <= res_index_d;
      res_err       <= res_err_d;
      busy          <= busy_d;
    end
  end

`ifdef SME_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_sme_feeder.sv
// Scoreboard bench for sme_feeder: a line-level model predicts bursts and results, a monitor
// compares them as the DUT presents them.
module tb_sme_feeder;
  localparam int unsigned STR_MAX = 32;
  localparam int unsigned PAT_MAX = 8;
`ifdef SME_FEEDER_TIMEOUT_EN
  localparam int unsigned TIMEOUT = 64;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_kind, in_last, in_valid, in_ready;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       sme_valid, sme_match;
  logic [4:0] sme_index;
  logic       res_valid, res_match;
  logic [4:0] res_index;
  logic [1:0] res_err;
  logic       busy;

  sme_feeder dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_kind  (in_kind),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .chardata (chardata),
    .isstring (isstring),
    .ispattern(ispattern),
    .sme_valid(sme_valid),
    .sme_match(sme_match),
    .sme_index(sme_index),
    .res_valid(res_valid),
    .res_match(res_match),
    .res_index(res_index),
    .res_err  (res_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {logic marker; logic is_pat; logic [7:0] data;} beat_t;
  typedef struct packed {logic match; logic [4:0] index; logic [1:0] err;} res_t;
  beat_t exp_beats[$];
  res_t  exp_res[$];
  int    wait_entry_cyc = 0;
  int    res_cyc = 0;

  // Line-level reference state
  bit         m_pending, m_seen, m_trunc;
  logic [7:0] m_str [64];
  int         m_slen;
  logic [7:0] str_src [64];
  logic [7:0] pat_src [64];
  logic [7:0] line_buf [64];
  int         s_len, p_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor
  logic  prev_strobe = 1'b0;
  beat_t mb;
  res_t  mr;
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      prev_strobe = 1'b0;
    end else begin
      chk("strobe_exclusive", {31'd0, isstring & ispattern}, 0);
      if (isstring | ispattern) begin
        if (exp_beats.size() != 0 && !exp_beats[0].marker) begin
          mb = exp_beats.pop_front();
          chk("burst_kind", {31'd0, ispattern}, {31'd0, mb.is_pat});
          chk("burst_data", {24'd0, chardata}, {24'd0, mb.data});
        end else begin
          chk("unexpected_strobe", {30'd0, isstring, ispattern}, 0);
        end
      end else if (prev_strobe) begin
        chk("burst_end_in_place",
            {31'd0, exp_beats.size() != 0 && exp_beats[0].marker}, 1);
        if (exp_beats.size() != 0 && exp_beats[0].marker) begin
          void'(exp_beats.pop_front());
          wait_entry_cyc = cyc;
        end
      end
      prev_strobe = isstring | ispattern;
      if (res_valid) begin
        if (exp_res.size() != 0) begin
          mr = exp_res.pop_front();
          res_cyc = cyc;
          chk("res_match", {31'd0, res_match}, {31'd0, mr.match});
          chk("res_index", {27'd0, res_index}, {27'd0, mr.index});
          chk("res_err", {30'd0, res_err}, {30'd0, mr.err});
        end else begin
          chk("unexpected_res_valid", {31'd0, res_valid}, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && in_ready !== 1'b1; n++) tick();
    chk("idle_wait", {31'd0, in_ready}, 1);
  endtask

  task automatic drain_beats();
    for (int n = 0; n < 200 && exp_beats.size() != 0; n++) tick();
    chk("burst_drain", exp_beats.size(), 0);
    exp_beats.delete();
  endtask

  task automatic drain_res();
    for (int n = 0; n < 200 && exp_res.size() != 0; n++) tick();
    chk("result_drain", exp_res.size(), 0);
    exp_res.delete();
  endtask

  task automatic set_str(input string s);
    s_len = s.len();
    for (int i = 0; i < s_len; i++) str_src[i] = s[i];
  endtask

  task automatic set_pat(input string s);
    p_len = s.len();
    for (int i = 0; i < p_len; i++) pat_src[i] = s[i];
  endtask

  task automatic fill_random(input int slen, input int plen);
    s_len = slen;
    p_len = plen;
    for (int i = 0; i < slen; i++) str_src[i] = 8'($urandom_range(32, 126));
    for (int i = 0; i < plen; i++) pat_src[i] = 8'($urandom_range(32, 126));
  endtask

  task automatic drive_line(input bit kind, input int len, input bit gappy);
    int stalls = 0;
    for (int i = 0; i < len; i++) begin
      if (gappy) begin
        in_valid  = 1'b0;
        sme_valid = 1'($urandom_range(0, 1));
        sme_match = 1'($urandom);
        sme_index = 5'($urandom);
        tick();
        sme_valid = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = line_buf[i];
      in_kind  = (i == 0) ? kind : 1'($urandom);
      in_last  = (i == len - 1);
      if (in_ready !== 1'b1) stalls++;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'($urandom);
    chk("in_ready_held", stalls, 0);
  endtask

  task automatic load_string(input int slen, input bit gappy);
    wait_idle();
    for (int i = 0; i < slen; i++) line_buf[i] = str_src[i];
    drive_line(1'b0, slen, gappy);
    for (int i = 0; i < slen; i++) m_str[i] = str_src[i];
    m_slen    = slen;
    m_pending = 1'b1;
    m_seen    = 1'b1;
    if (slen > STR_MAX) m_trunc = 1'b1;
  endtask

  task automatic send_pattern(input int plen, input bit gappy, output bit strobes);
    bit    pend_was;
    beat_t b;
    res_t  r;
    wait_idle();
    if (plen > PAT_MAX) m_trunc = 1'b1;
    strobes  = m_seen;
    pend_was = m_pending;
    if (!m_seen) begin
      r = {1'b0, 5'd0, 1'b1, m_trunc};
      exp_res.push_back(r);
      m_trunc = 1'b0;
    end else begin
      if (m_pending) begin
        for (int i = 0; i < m_slen && i < STR_MAX; i++) begin
          b = {1'b0, 1'b0, m_str[i]};
          exp_beats.push_back(b);
        end
        m_pending = 1'b0;
      end
      for (int i = 0; i < plen && i < PAT_MAX; i++) begin
        b = {1'b0, 1'b1, pat_src[i]};
        exp_beats.push_back(b);
      end
      b = {1'b1, 1'b0, 8'd0};
      exp_beats.push_back(b);
    end
    for (int i = 0; i < plen; i++) line_buf[i] = pat_src[i];
    drive_line(1'b1, plen, gappy);
    chk("first_strobe_latency", {30'd0, isstring, ispattern},
        strobes ? (pend_was ? 32'd2 : 32'd1) : 32'd0);
  endtask

  task automatic finish_job(input bit strobes, input logic m, input logic [4:0] idx,
                            input bit respond);
    res_t r;
    if (strobes) begin
      drain_beats();
      if (respond) begin
        repeat ($urandom_range(0, 4)) tick();
        r = {m, idx, 1'b0, m_trunc};
        exp_res.push_back(r);
        m_trunc   = 1'b0;
        sme_valid = 1'b1;
        sme_match = m;
        sme_index = idx;
        tick();
        sme_valid = 1'b0;
        sme_match = 1'($urandom);
        sme_index = 5'($urandom);
      end else begin
`ifdef SME_FEEDER_TIMEOUT_EN
        r = {1'b0, 5'd0, 1'b1, m_trunc};
        exp_res.push_back(r);
        m_trunc = 1'b0;
`endif
      end
    end
    drain_res();
    chk("ready_after_job", {31'd0, in_ready}, 1);
    chk("busy_after_job", {31'd0, busy}, 0);
  endtask

  task automatic do_job(input bit new_str, input bit gappy, input logic m,
                        input logic [4:0] idx);
    bit strobes;
    if (new_str) load_string(s_len, gappy);
    send_pattern(p_len, gappy, strobes);
    finish_job(strobes, m, idx, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit strobes;
    reset = 1'b0;
    in_data = 8'd0; in_kind = 1'b0; in_last = 1'b0; in_valid = 1'b0;
    sme_valid = 1'b0; sme_match = 1'b0; sme_index = 5'd0;
    m_pending = 1'b0; m_seen = 1'b0; m_trunc = 1'b0; m_slen = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_chardata", {24'd0, chardata}, 0);
    chk("rst_strobes", {30'd0, isstring, ispattern}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_res", {24'd0, res_match, res_index, res_err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    @(posedge clk);
    #2 reset = 1'b1;

    // Pattern with no string since reset
    set_pat("xy");
    do_job(1'b0, 1'b0, 1'b1, 5'd7);

    // String then pattern, then pattern reusing the held string
    set_str("ab cd");
    set_pat("cd");
    do_job(1'b1, 1'b0, 1'b1, 5'd3);
    set_pat("^ab");
    do_job(1'b0, 1'b0, 1'b0, 5'd17);

    // Truncation on both lines
    fill_random(40, 11);
    do_job(1'b1, 1'b0, 1'b1, 5'd9);

    // Gappy input with stray matcher pulses during load
    fill_random(12, 5);
    do_job(1'b1, 1'b1, 1'b0, 5'd21);

    for (int j = 0; j < 25; j++) begin
      fill_random($urandom_range(1, 40), $urandom_range(1, 11));
      do_job((j == 0) || ($urandom_range(0, 1) == 1), 1'($urandom), 1'($urandom), 5'($urandom));
    end

    // Reset in the middle of the string burst
    fill_random(20, 4);
    load_string(20, 1'b0);
    send_pattern(4, 1'b0, strobes);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("midrst_isstring", {31'd0, isstring}, 0);
    chk("midrst_ispattern", {31'd0, ispattern}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    exp_beats.delete();
    exp_res.delete();
    m_pending = 1'b0; m_seen = 1'b0; m_trunc = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) tick();
    chk("postrst_in_ready", {31'd0, in_ready}, 1);
    chk("postrst_busy", {31'd0, busy}, 0);
    repeat (10) tick();
    set_pat("q");
    do_job(1'b0, 1'b0, 1'b1, 5'd1);
    set_str("z");
    set_pat("z");
    do_job(1'b1, 1'b0, 1'b1, 5'd0);

`ifdef SME_FEEDER_TIMEOUT_EN
    fill_random(5, 3);
    load_string(5, 1'b0);
    send_pattern(3, 1'b0, strobes);
    finish_job(strobes, 1'b0, 5'd0, 1'b0);
    chk("timeout_latency", res_cyc - wait_entry_cyc, TIMEOUT);
`endif

    repeat (5) tick();
    chk("queues_empty", exp_beats.size() + exp_res.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
